// File: rtl/rpi_reg_rx.sv
// RPi-to-TI half of the TIPI register interface: synchronizes the RPi serial
// link into the RD/RC byte registers and presents them on the TI data bus.
module rpi_reg_rx #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [15:0] RD_ADDR     = 16'h5ffb,
  parameter logic [15:0] RC_ADDR     = 16'h5ff9
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rpi_dclk,
  input  logic        rpi_cclk,
  input  logic        rpi_sdata,
  input  logic        rpi_le,
  input  logic [0:15] ti_a,
  input  logic        ti_memen,
  input  logic        ti_dbin,
  input  logic        crubit_q,
  output logic [7:0]  rd,
  output logic [7:0]  rc,
  output logic [0:7]  dbus_q,
  output logic        dbus_oe_n,
  output logic        rd_fresh,
  output logic        frame_err
);

  localparam int NSYNC = 5;

  logic             rd_sel_s;
  logic             rc_sel_s;
  logic [NSYNC-1:0] async_in_s;
  logic [NSYNC-1:0] synced_s;
  logic [NSYNC-1:0] sync_r [SYNC_STAGES];
  logic [3:0]       edge_now_s;
  logic [3:0]       prev_r;
  logic [3:0]       rise_s;
  logic             dclk_rise_r;
  logic             cclk_rise_r;
  logic             le_rise_r;
  logic             sdata_r;
  logic [7:0]       dsr_r;
  logic [7:0]       csr_r;
  logic [3:0]       dcnt_r;
  logic [3:0]       ccnt_r;
  logic [7:0]       rd_r;
  logic [7:0]       rc_r;
  logic             rd_fresh_r;
  logic             frame_err_r;
  logic             bad_d_s;
  logic             bad_c_s;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    sat_inc = (v == 4'd15) ? 4'd15 : v + 4'd1;
  endfunction

  assign rd_sel_s = crubit_q & ~ti_memen & ti_dbin & (ti_a == RD_ADDR);
  assign rc_sel_s = crubit_q & ~ti_memen & ti_dbin & (ti_a == RC_ADDR);

  // Bit order of every synchronizer word: {rd_sel, le, sdata, cclk, dclk}.
  assign async_in_s = {rd_sel_s, rpi_le, rpi_sdata, rpi_cclk, rpi_dclk};
  assign synced_s   = sync_r[SYNC_STAGES-1];
  assign edge_now_s = {synced_s[4], synced_s[3], synced_s[1], synced_s[0]};
  assign rise_s     = edge_now_s & ~prev_r;

  assign bad_d_s = (dcnt_r != 4'd0) && (dcnt_r != 4'd8);
  assign bad_c_s = (ccnt_r != 4'd0) && (ccnt_r != 4'd8);

  // Synchronizer chains and edge-detect history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_r[i] <= '0;
      prev_r <= 4'd0;
    end else begin
      sync_r[0] <= async_in_s;
      for (int i = 1; i < SYNC_STAGES; i++) sync_r[i] <= sync_r[i-1];
      prev_r <= edge_now_s;
    end
  end

  // Edge pulses are registered once more, sdata alongside, so it stays aligned
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dclk_rise_r <= 1'b0;
      cclk_rise_r <= 1'b0;
      le_rise_r   <= 1'b0;
      sdata_r     <= 1'b0;
    end else begin
      dclk_rise_r <= rise_s[0];
      cclk_rise_r <= rise_s[1];
      le_rise_r   <= rise_s[2];
      sdata_r     <= synced_s[2];
    end
  end

  // Shift/count, or commit; a shift edge coinciding with commit is dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dsr_r       <= 8'h00;
      csr_r       <= 8'h00;
      dcnt_r      <= 4'd0;
      ccnt_r      <= 4'd0;
      rd_r        <= 8'h00;
      rc_r        <= 8'h00;
      frame_err_r <= 1'b0;
    end else if (le_rise_r) begin
      if (dcnt_r == 4'd8) rd_r <= dsr_r;
      if (ccnt_r == 4'd8) rc_r <= csr_r;
      if (bad_d_s || bad_c_s) frame_err_r <= 1'b1;
      dcnt_r <= 4'd0;
      ccnt_r <= 4'd0;
    end else begin
      if (dclk_rise_r) begin
        dsr_r  <= {dsr_r[6:0], sdata_r};
        dcnt_r <= sat_inc(dcnt_r);
      end
      if (cclk_rise_r) begin
        csr_r  <= {csr_r[6:0], sdata_r};
        ccnt_r <= sat_inc(ccnt_r);
      end
    end
  end

  // Fresh flag: a landing RD commit takes priority over a TI read clearing it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_fresh_r <= 1'b0;
    end else if (le_rise_r && (dcnt_r == 4'd8)) begin
      rd_fresh_r <= 1'b1;
    end else if (rise_s[3]) begin
      rd_fresh_r <= 1'b0;
    end
  end

  // TI read mux; the TI bus is asynchronous so this path is combinational
  always_comb begin
    dbus_oe_n = 1'b1;
    dbus_q    = 8'h00;
    if (rd_sel_s) begin
      dbus_oe_n = 1'b0;
      dbus_q    = rd_r;
    end else if (rc_sel_s) begin
      dbus_oe_n = 1'b0;
      dbus_q    = rc_r;
    end else begin
      dbus_oe_n = 1'b1;
      dbus_q    = 8'h00;
    end
  end

  assign rd        = rd_r;
  assign rc        = rc_r;
  assign rd_fresh  = rd_fresh_r;
  assign frame_err = frame_err_r;

endmodule

// File: tb/tb_rpi_reg_rx.sv
// Randomized scoreboard bench for rpi_reg_rx: the driver pushes timed expected
// states, a negedge monitor pops and compares them.
module tb_rpi_reg_rx;

  localparam int S  = 2;
  localparam int PH = S + 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rpi_dclk = 1'b0, rpi_cclk = 1'b0, rpi_sdata = 1'b0, rpi_le = 1'b0;
  logic [0:15] ti_a = 16'h0000;
  logic        ti_memen = 1'b1, ti_dbin = 1'b0, crubit_q = 1'b0;
  logic [7:0]  rd, rc;
  logic [0:7]  dbus_q;
  logic        dbus_oe_n, rd_fresh, frame_err;

  rpi_reg_rx #(.SYNC_STAGES(S), .RD_ADDR(16'h5ffb), .RC_ADDR(16'h5ff9)) dut (
    .clk(clk), .rst_n(rst_n), .rpi_dclk(rpi_dclk), .rpi_cclk(rpi_cclk),
    .rpi_sdata(rpi_sdata), .rpi_le(rpi_le), .ti_a(ti_a), .ti_memen(ti_memen),
    .ti_dbin(ti_dbin), .crubit_q(crubit_q), .rd(rd), .rc(rc), .dbus_q(dbus_q),
    .dbus_oe_n(dbus_oe_n), .rd_fresh(rd_fresh), .frame_err(frame_err)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int         due;
    logic [7:0] rd, rc, q;
    logic       fresh, err, oe_n;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: architectural state plus the bits sent since the last commit
  logic [7:0] m_rd = 8'h00, m_rc = 8'h00;
  logic       m_fresh = 1'b0, m_err = 1'b0;
  bit         dq[$], cq[$];

  task automatic push(input int due, input logic oe_n, input logic [7:0] q);
    exp_t e;
    e.due = due; e.rd = m_rd; e.rc = m_rc; e.q = q;
    e.fresh = m_fresh; e.err = m_err; e.oe_n = oe_n;
    sb.push_back(e);
  endtask

  task automatic chk(input string nm, input int due, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", nm, due, act, exp);
    end
  endtask

  // Monitor: compare the DUT against each expected state when its cycle comes up
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        if (e.due != cyc) begin
          miscompares++;
          $display("FAIL late_check due %0d seen at %0d", e.due, cyc);
        end
        chk("rd", e.due, rd, e.rd);
        chk("rc", e.due, rc, e.rc);
        chk("rd_fresh", e.due, {7'd0, rd_fresh}, {7'd0, e.fresh});
        chk("frame_err", e.due, {7'd0, frame_err}, {7'd0, e.err});
        chk("dbus_oe_n", e.due, {7'd0, dbus_oe_n}, {7'd0, e.oe_n});
        chk("dbus_q", e.due, dbus_q, e.q);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic shift_bit(input bit b, input bit d, input bit c);
    rpi_sdata = b;
    tick(PH);
    rpi_dclk = d; rpi_cclk = c;
    tick(PH);
    rpi_dclk = 1'b0; rpi_cclk = 1'b0;
    if (d) dq.push_back(b);
    if (c) cq.push_back(b);
  endtask

  task automatic send_bits(input logic [7:0] v, input bit d, input bit c, input int n);
    for (int k = 0; k < n; k++) shift_bit(v[7 - (k % 8)], d, c);
  endtask

  // Commit strobe; with_dclk raises dclk on the same cycle, so that bit is lost
  task automatic commit(input bit with_dclk, input bit b);
    int         n;
    logic [7:0] v;
    rpi_sdata = b;
    tick(1);
    n = cyc;
    rpi_le = 1'b1;
    if (with_dclk) rpi_dclk = 1'b1;
    push(n + S + 1, 1'b1, 8'h00);
    if (dq.size() == 8) begin
      v = 8'h00;
      foreach (dq[i]) v = {v[6:0], dq[i]};
      m_rd = v; m_fresh = 1'b1;
    end
    if (cq.size() == 8) begin
      v = 8'h00;
      foreach (cq[i]) v = {v[6:0], cq[i]};
      m_rc = v;
    end
    if ((dq.size() != 0 && dq.size() != 8) || (cq.size() != 0 && cq.size() != 8)) m_err = 1'b1;
    dq.delete(); cq.delete();
    push(n + S + 2, 1'b1, 8'h00);
    tick(PH);
    rpi_le = 1'b0; rpi_dclk = 1'b0;
    tick(PH);
  endtask

  task automatic ti_read(input bit cru, input logic [15:0] addr);
    int         n;
    bit         sel_rd, sel_rc;
    logic [7:0] q;
    n = cyc;
    crubit_q = cru; ti_a = addr; ti_memen = 1'b0; ti_dbin = 1'b1;
    sel_rd = cru && (addr == 16'h5ffb);
    sel_rc = cru && (addr == 16'h5ff9);
    q = sel_rd ? m_rd : (sel_rc ? m_rc : 8'h00);
    push(n, !(sel_rd || sel_rc), q);
    if (sel_rd) m_fresh = 1'b0;
    push(n + S + 1, !(sel_rd || sel_rc), q);
    tick(S + 3);
    ti_memen = 1'b1; ti_dbin = 1'b0;
    tick(S + 2);
  endtask

  task automatic do_reset(input bit rand_inputs);
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (rand_inputs) begin
        rpi_dclk = 1'($urandom); rpi_cclk = 1'($urandom); rpi_sdata = 1'($urandom);
        rpi_le = 1'($urandom); ti_a = 16'($urandom); ti_memen = 1'($urandom);
        ti_dbin = 1'($urandom); crubit_q = 1'($urandom);
      end
      tick(1);
    end
    rpi_dclk = 1'b0; rpi_cclk = 1'b0; rpi_sdata = 1'b0; rpi_le = 1'b0;
    ti_memen = 1'b1; ti_dbin = 1'b0;
    tick(2);
    m_rd = 8'h00; m_rc = 8'h00; m_fresh = 1'b0; m_err = 1'b0;
    dq.delete(); cq.delete();
    rst_n = 1'b1;
    push(cyc, 1'b1, 8'h00);
    push(cyc + S + 2, 1'b1, 8'h00);
    tick(S + 3);
  endtask

  initial begin
    logic [7:0]  v;
    logic [15:0] addr;
    int          op, nb, sel;

    do_reset(1'b1);

    send_bits(8'hA5, 1'b1, 1'b0, 8); commit(1'b0, 1'b0);
    send_bits(8'h3C, 1'b0, 1'b1, 8); commit(1'b0, 1'b0);
    ti_read(1'b1, 16'h5ff9);

    send_bits(8'h7F, 1'b1, 1'b0, 7); commit(1'b0, 1'b0);
    send_bits(8'h11, 1'b1, 1'b0, 8); commit(1'b0, 1'b0);

    ti_read(1'b0, 16'h5ffb);
    ti_read(1'b1, 16'h5ffb);

    send_bits(8'h96, 1'b1, 1'b0, 8); commit(1'b1, 1'b1);

    send_bits(8'hC3, 1'b1, 1'b0, 4);
    do_reset(1'b0);
    send_bits(8'hC3, 1'b1, 1'b0, 8); commit(1'b0, 1'b0);
    ti_read(1'b1, 16'h5ffb);

    for (int it = 0; it < 40; it++) begin
      op = int'($urandom_range(0, 2));
      if (op == 0 || op == 1) begin
        v   = 8'($urandom);
        sel = int'($urandom_range(0, 2));
        nb  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 10)) : 8;
        send_bits(v, sel != 1, sel != 0, nb);
        commit($urandom_range(0, 5) == 0, 1'($urandom));
      end else begin
        case ($urandom_range(0, 2))
          0:       addr = 16'h5ffb;
          1:       addr = 16'h5ff9;
          default: addr = 16'($urandom);
        endcase
        ti_read(1'($urandom), addr);
      end
    end

    for (int i = 0; i < 200 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d checks pending, expected 0", sb.size());
    end
    tick(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
